prescaled_counter: RTL

//   Parametrised up/down counter with a built-in prescaler and three counting

---
 rtl/prescaled_counter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/prescaled_counter.sv
// Up/down counter with prescaler and WRAP / SATURATE / ONESHOT / HOLD modes.
// Optional compare output enabled by `PRESCALED_COUNTER_CMP_EN.
module prescaled_counter #(
    parameter int WIDTH     = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 en,
    input  logic                 up,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     max,
    input  logic [PRE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]     D,
`ifdef PRESCALED_COUNTER_CMP_EN
    input  logic [WIDTH-1:0]     cmp_val,
    output logic                 cmp_match,
`endif
    output logic [WIDTH-1:0]     Q,
    output logic                 tick,
    output logic                 tc,
    output logic                 done
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    logic [WIDTH-1:0]     q_q, q_d;
    logic [PRE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                 tick_q, tick_d;
    logic                 tc_q, tc_d;
    logic                 done_q, done_d;
    logic                 step;
    logic                 term;
    logic [WIDTH-1:0]     q_next;

    always_comb begin
        q_d    = q_q;
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        done_d = done_q;
        step   = 1'b0;
        term   = 1'b0;
        q_next = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));

        if (clear) begin
            q_d    = '0;
            pcnt_d = '0;
            done_d = 1'b0;
        end else if (load) begin
            q_d    = D;
            pcnt_d = '0;
            done_d = 1'b0;
        end else if (en) begin
            // >= rather than == so a prescale lowered below pcnt steps at once
            if (pcnt_q >= prescale) begin
                step   = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PRE_WIDTH'(1);
            end
        end

        if (step) begin
            tick_d = 1'b1;
            term   = up ? (q_q >= max) : (q_q == '0);
            case (mode)
                MODE_WRAP: begin
                    if (term) begin
                        q_d  = up ? '0 : max;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_next;
                    end
                end
                MODE_SAT: begin
                    if (term) tc_d = 1'b1;
                    else      q_d  = q_next;
                end
                MODE_ONESHOT: begin
                    if (!done_q) begin
                        if (term) begin
                            tc_d   = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            q_d = q_next;
                        end
                    end
                end
                MODE_HOLD: begin
                    q_d = q_q;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            q_q    <= '0;
            pcnt_q <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign Q    = q_q;
    assign tick = tick_q;
    assign tc   = tc_q;
    assign done = done_q;

`ifdef PRESCALED_COUNTER_CMP_EN
    logic cmp_match_q, cmp_match_d;

    // Only edges that write Q can match; an idle cycle sitting on cmp_val does not
    always_comb begin
        cmp_match_d = (clear || load || step) && (q_d == cmp_val);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) cmp_match_q <= 1'b0;
        else          cmp_match_q <= cmp_match_d;
    end

    assign cmp_match = cmp_match_q;
`endif

endmodule
